// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - write-back source codes, load funct3 constants and FSM state encoding
package riscv_wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a load word and sign/zero-extends it
module load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword loads ignore off[0]: only the two naturally aligned halves are reachable.
    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   word = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  word = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   word = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  word = {{(XLEN-16){1'b0}}, half_v};
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/wb_select.sv
// rtl/wb_select.sv - write-back source select and load handshake; WB_TIMEOUT_EN adds a WAIT_MEM abort timer
module wb_select
    import riscv_wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      wb_src,
    input  logic            reg_write,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy,
    output logic            done,
    output logic            err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_select: TIMEOUT must be at least 1");
    end

    wb_state_e       state_q, state_d;
    wb_src_e         src_q;
    logic            regw_q;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] alu_q, pc4_q, imm_q;

    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            capture, enter_write, abort;
    logic            from_inputs;
    wb_src_e         sel_src;
    logic            sel_regw;
    logic [4:0]      sel_rd;
    logic [2:0]      sel_f3;
    logic [XLEN-1:0] sel_alu, sel_pc4, sel_imm, pc4_in, load_word, sel_value;

    // A non-load retires the cycle after start, before the capture registers are
    // loaded, so the operand set comes straight from the inputs while in IDLE.
    assign from_inputs = (state_q == IDLE);
    assign pc4_in      = pc + XLEN'(4);
    assign sel_src     = from_inputs ? wb_src_e'(wb_src) : src_q;
    assign sel_regw    = from_inputs ? reg_write         : regw_q;
    assign sel_rd      = from_inputs ? rd                : rd_q;
    assign sel_f3      = from_inputs ? funct3            : f3_q;
    assign sel_alu     = from_inputs ? alu_result        : alu_q;
    assign sel_pc4     = from_inputs ? pc4_in            : pc4_q;
    assign sel_imm     = from_inputs ? imm               : imm_q;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (mem_rdata),
        .off    (sel_alu[1:0]),
        .funct3 (sel_f3),
        .word   (load_word)
    );

    always_comb begin
        case (sel_src)
            WB_MEM:  sel_value = load_word;
            WB_PC4:  sel_value = sel_pc4;
            WB_IMM:  sel_value = sel_imm;
            default: sel_value = sel_alu;
        endcase
    end

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timed_out;
    logic          err_q;

    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
    assign cnt_d     = (state_q == WAIT_MEM) ? cnt_q + CW'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= abort;
        end
    end
    assign err = err_q;
`else
    logic timed_out;
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = (wb_src_e'(wb_src) == WB_MEM) ? WAIT_MEM : WRITE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = WRITE;
                end else if (timed_out) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        enter_write = (state_d == WRITE);
        rf_we_d     = enter_write && sel_regw && (sel_rd != 5'd0);
        rf_waddr_d  = enter_write ? sel_rd    : rf_waddr_q;
        rf_wdata_d  = enter_write ? sel_value : rf_wdata_q;
        done_d      = enter_write || abort;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= WB_ALU;
            regw_q     <= 1'b0;
            rd_q       <= '0;
            f3_q       <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (capture) begin
                src_q  <= wb_src_e'(wb_src);
                regw_q <= reg_write;
                rd_q   <= rd;
                f3_q   <= funct3;
                alu_q  <= alu_result;
                pc4_q  <= pc4_in;
                imm_q  <= imm;
            end
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wb_select.sv
// tb/tb_wb_select.sv - directed self-checking bench for wb_select
module tb_wb_select;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  wb_src = 2'd0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    wb_select #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .wb_src     (wb_src),
        .reg_write  (reg_write),
        .rd         (rd),
        .funct3     (funct3),
        .alu_result (alu_result),
        .pc         (pc),
        .imm        (imm),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] src, input logic regw, input logic [4:0] r,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] p, input logic [31:0] im);
        start = 1'b1; wb_src = src; reg_write = regw; rd = r; funct3 = f3;
        alu_result = alu; pc = p; imm = im;
        tick();
        start = 1'b0; wb_src = 2'd0; rd = 5'd0; alu_result = 32'd0; pc = 32'd0; imm = 32'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        checks++; if (rf_we !== 1'b0)        begin errors++; $display("FAIL reset_we got %0b exp 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0)     begin errors++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0)    begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0)         begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (err !== 1'b0)          begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu;
        issue(2'd0, 1'b1, 5'd5, 3'd0, 32'h0000_1234, 32'h0000_0100, 32'h0000_0777);
        checks++; if (rf_we !== 1'b1)          begin errors++; $display("FAIL alu_we got %0b exp 1", rf_we); end
        checks++; if (rf_waddr !== 5'd5)       begin errors++; $display("FAIL alu_waddr got %0d exp 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h1234)   begin errors++; $display("FAIL alu_wdata got %h exp 00001234", rf_wdata); end
        checks++; if (done !== 1'b1)           begin errors++; $display("FAIL alu_done got %0b exp 1", done); end
        checks++; if (busy !== 1'b1)           begin errors++; $display("FAIL alu_busy got %0b exp 1", busy); end
        checks++; if (err !== 1'b0)            begin errors++; $display("FAIL alu_err got %0b exp 0", err); end
        tick();
        checks++; if (rf_we !== 1'b0)          begin errors++; $display("FAIL alu_we_drop got %0b exp 0", rf_we); end
        checks++; if (done !== 1'b0)           begin errors++; $display("FAIL alu_done_drop got %0b exp 0", done); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL alu_busy_drop got %0b exp 0", busy); end
        checks++; if (rf_wdata !== 32'h1234)   begin errors++; $display("FAIL alu_wdata_hold got %h exp 00001234", rf_wdata); end
        checks++; if (rf_waddr !== 5'd5)       begin errors++; $display("FAIL alu_waddr_hold got %0d exp 5", rf_waddr); end
    endtask

    task automatic test_imm;
        issue(2'd3, 1'b1, 5'd31, 3'd0, 32'h1111_1111, 32'h0000_0040, 32'hDEAD_BEEF);
        checks++; if (rf_we !== 1'b1)           begin errors++; $display("FAIL imm_we got %0b exp 1", rf_we); end
        checks++; if (rf_waddr !== 5'd31)       begin errors++; $display("FAIL imm_waddr got %0d exp 31", rf_waddr); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL imm_wdata got %h exp deadbeef", rf_wdata); end
        tick();
    endtask

    task automatic test_loads;
        logic [2:0]  f3_t  [9] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b100, 3'b000, 3'b001, 3'b010, 3'b011};
        logic [1:0]  off_t [9] = '{2'd3,   2'd3,   2'd2,   2'd2,   2'd1,   2'd0,   2'd1,   2'd2,   2'd1};
        logic [31:0] exp_t [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF,
                                   32'h0000_0012, 32'h0000_0034, 32'h0000_1234, 32'h80FF_1234,
                                   32'h80FF_1234};
        for (int i = 0; i < 9; i++) begin
            issue(2'd1, 1'b1, 5'd10, f3_t[i], {30'h0000_0400, off_t[i]}, 32'd0, 32'd0);
            tick(); tick();
            checks++; if (done !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL load%0d_wait got done=%0b busy=%0b exp done=0 busy=1", i, done, busy); end
            mem_rdata = 32'h80FF_1234; mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0; mem_rdata = 32'd0;
            checks++; if (rf_wdata !== exp_t[i])
                begin errors++; $display("FAIL load%0d_wdata got %h exp %h", i, rf_wdata, exp_t[i]); end
            checks++; if (rf_we !== 1'b1 || done !== 1'b1 || rf_waddr !== 5'd10)
                begin errors++; $display("FAIL load%0d_pulse got we=%0b done=%0b waddr=%0d exp 1 1 10", i, rf_we, done, rf_waddr); end
            tick();
        end
    endtask

    task automatic test_pc4;
        issue(2'd2, 1'b1, 5'd0, 3'd0, 32'd0, 32'hFFFF_FFFC, 32'd0);
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL pc4_rd0_done got %0b exp 1", done); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pc4_rd0_we got %0b exp 0", rf_we); end
        tick();
        issue(2'd2, 1'b1, 5'd1, 3'd0, 32'd0, 32'hFFFF_FFFC, 32'd0);
        checks++; if (rf_we !== 1'b1)          begin errors++; $display("FAIL pc4_wrap_we got %0b exp 1", rf_we); end
        checks++; if (rf_wdata !== 32'd0)      begin errors++; $display("FAIL pc4_wrap_wdata got %h exp 00000000", rf_wdata); end
        tick();
        issue(2'd2, 1'b0, 5'd3, 3'd0, 32'd0, 32'h0000_1000, 32'd0);
        checks++; if (done !== 1'b1 || rf_we !== 1'b0)
            begin errors++; $display("FAIL nowrite got done=%0b we=%0b exp done=1 we=0", done, rf_we); end
        checks++; if (rf_wdata !== 32'h0000_1004) begin errors++; $display("FAIL nowrite_wdata got %h exp 00001004", rf_wdata); end
        tick();
    endtask

    task automatic test_back_to_back;
        // Second start while still in WAIT_MEM must be dropped.
        issue(2'd1, 1'b1, 5'd7, 3'b010, 32'h0000_0200, 32'd0, 32'd0);
        issue(2'd0, 1'b1, 5'd9, 3'd0, 32'h5555_5555, 32'd0, 32'd0);
        checks++; if (busy !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL b2b_ignored got busy=%0b done=%0b exp 1 0", busy, done); end
        mem_rdata = 32'hA5A5_0F0F; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'hA5A5_0F0F || rf_we !== 1'b1)
            begin errors++; $display("FAIL b2b_load got waddr=%0d wdata=%h we=%0b exp 7 a5a50f0f 1", rf_waddr, rf_wdata, rf_we); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL b2b_after got done=%0b busy=%0b exp 0 0", done, busy); end
        // A start in the WRITE cycle is dropped; one in the following IDLE cycle is taken.
        issue(2'd3, 1'b1, 5'd2, 3'd0, 32'd0, 32'd0, 32'h0000_0022);
        issue(2'd3, 1'b1, 5'd4, 3'd0, 32'd0, 32'd0, 32'h0000_0044);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_write_start got done=%0b exp 0", done); end
        issue(2'd3, 1'b1, 5'd6, 3'd0, 32'd0, 32'd0, 32'h0000_0066);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66)
            begin errors++; $display("FAIL b2b_next got we=%0b waddr=%0d wdata=%h exp 1 6 00000066", rf_we, rf_waddr, rf_wdata); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        tick(); tick();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b0 || rf_we !== 1'b0)
            begin errors++; $display("FAIL idle_rvalid got done=%0b we=%0b exp 0 0", done, rf_we); end
    endtask

    task automatic test_reset_mid;
        issue(2'd1, 1'b1, 5'd12, 3'b010, 32'h0000_0300, 32'd0, 32'd0);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b exp 0", busy); end
        tick();
        rst = 1'b0;
        mem_rdata = 32'hFFFF_0000; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_after got we=%0b done=%0b busy=%0b exp 0 0 0", rf_we, done, busy); end
        tick();
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout;
        logic early;
        early = 1'b0;
        issue(2'd1, 1'b1, 5'd8, 3'b010, 32'h0000_0500, 32'd0, 32'd0);
        for (int i = 0; i < 15; i++) begin
            if (done) early = 1'b1;
            tick();
        end
        if (done) early = 1'b1;
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early got done-seen=%0b exp 0", early); end
        tick();
        checks++; if (done !== 1'b1 || err !== 1'b1 || rf_we !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL to_abort got done=%0b err=%0b we=%0b busy=%0b exp 1 1 0 0", done, err, rf_we, busy); end
        mem_rdata = 32'h7777_7777; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b0 || err !== 1'b0 || rf_we !== 1'b0)
            begin errors++; $display("FAIL to_late got done=%0b err=%0b we=%0b exp 0 0 0", done, err, rf_we); end
        tick();
    endtask
`else
    task automatic test_no_timeout;
        logic seen;
        seen = 1'b0;
        issue(2'd1, 1'b1, 5'd8, 3'b010, 32'h0000_0500, 32'd0, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (done || err) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL wait_forever got seen=%0b busy=%0b exp 0 1", seen, busy); end
        mem_rdata = 32'hCAFE_F00D; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hCAFE_F00D || err !== 1'b0)
            begin errors++; $display("FAIL wait_finish got we=%0b wdata=%h err=%0b exp 1 cafef00d 0", rf_we, rf_wdata, err); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_imm();
        test_loads();
        test_pc4();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
